sa3d_mm2s_tx: RTL and testbench
===============================

// Module: sa3d_mm2s_tx
// PURPOSE
// - Output-side AXI4-Stream transmitter of the SA3D accelerator: the mm2s counterpart to the s2mm input stream.
// - Accepts result beats from the systolic-array write-back, buffers them in a FIFO and emits m_axis_mm2s_* toward the DMA.
// - Generates tkeep for partial row tails and tlast on the final beat of each output matrix (OutMatrix_Row x OutMatrix_Col int8).
// PARAMETERS
// - DATA_W      64   beat width; LANES = DATA_W/8 int8 lanes
// - FIFO_DEPTH  16   result buffer depth; must be a power of 2, >=2
// - DIM_W       16   width of the row/column configuration inputs
// PORTS
// - clk                         in   1       system clock
// - reset                       in   1       synchronous, active-high reset
// - Control_start               in   1       1-cycle pulse; latches config, clears counters/FIFO, starts a frame
// - Img2Col_OutMatrix_Row       in   DIM_W   output rows per frame (e.g. 49284)
// - Img2Col_OutMatrix_Col       in   DIM_W   output columns (int8 elements) per row (e.g. 128)
// - res_valid / res_ready       in/out 1     result-beat handshake from array write-back
// - res_data                    in   DATA_W  result beat; lane 0 = bits[7:0] = lowest column
// - m_axis_mm2s_tdata           out  DATA_W  stream data
// - m_axis_mm2s_tkeep           out  LANES   byte enables
// - m_axis_mm2s_tlast           out  1       last beat of frame
// - m_axis_mm2s_tvalid/tready   out/in 1     stream handshake
// - busy                        out  1       frame in progress
// - done                        out  1       1-cycle pulse after the tlast beat is accepted
// - stall_cnt                   out  32      only with SA3D_MM2S_STALL_CNT_EN
// BEHAVIOUR
// - Reset values: res_ready=0, tvalid=0, tlast=0, tkeep=0, tdata=0, busy=0, done=0, stall_cnt=0; FIFO empty; state IDLE.
// - beats_per_row BPR = ceil(Col/LANES); total = Row*BPR (32-bit product); latched at Control_start.
// - FSM IDLE -> RUN on Control_start. RUN -> DRAIN when total beats have been accepted on res side.
//   DRAIN -> IDLE when the tlast beat handshakes; done=1 in the following cycle.
// - Control_start while RUN/DRAIN: abort the frame. FIFO and counters are cleared, tvalid=0 next cycle, the new config is latched, and the FSM stays in RUN.
//   No done pulse is issued for the aborted frame.
// - Row==0 or Col==0 at start: no beats are sent, done pulses 1 cycle after start, and the FSM returns to IDLE.
// - res_ready = (state==RUN) && FIFO not full && in_cnt<total. Beats arriving outside RUN are ignored.
// - FIFO is first-word-fall-through with registered output. With an empty FIFO, a res handshake at cycle N gives tvalid at N+1.
//   Sustained throughput is 1 beat/cycle with simultaneous push/pop allowed when full.
// - AXI rule: once tvalid=1, tdata/tkeep/tlast are held stable until tready. tvalid never depends on tready.
// - Output counters col_beat (0..BPR-1, wraps) and row (0..Row-1) advance on tvalid&&tready.
// - tkeep = all-ones, except on col_beat==BPR-1 when Col%LANES!=0: tkeep = (1<<(Col%LANES))-1.
// - tlast = 1 only when col_beat==BPR-1 and row==Row-1.
// - Synchronous reset at any time aborts immediately to the reset values. It has priority over Control_start.
// CONFIGURATION
// - SA3D_MM2S_STALL_CNT_EN defined: stall_cnt counts cycles with tvalid&&!tready in the current frame.
//   It clears on Control_start, saturates at 2^32-1 and holds after done.
// - SA3D_MM2S_STALL_CNT_EN undefined: the stall_cnt port and its logic are absent.
// STRUCTURE
// - Shared package sa3d_pkg: DATA_W/LANES constants, state enum {IDLE,RUN,DRAIN}, function ceil_div_lanes().
// - One sub-module, sa3d_sync_fifo_fwft (DATA_W, FIFO_DEPTH), with a sync clear used on abort.
//   Top level holds the FSM, counters and tkeep/tlast logic.
// TESTING
// 1. Row=2, Col=16, tready=1: 4 beats, tkeep=0xFF on all, tlast on beat 4 only; done 1 cycle after beat 4.
// 2. Row=3, Col=20: 9 beats; beats 3, 6, 9 have tkeep=0x0F, others 0xFF; tlast on beat 9 only.
// 3. Row=4, Col=128, res_valid=1, tready high 1 cycle in 4: FIFO fills, res_ready drops at 16 entries.
//    All 64 beats arrive in order with data unchanged during stalls.
//    With SA3D_MM2S_STALL_CNT_EN: stall_cnt equals the bench-counted stall cycles.
// 4. Control_start after 5 output beats of a Row=8, Col=64 frame: tvalid=0 next cycle, no done.
//    The new frame's first beat equals its first res_data; count restarts at 0.
// 5. reset=1 mid-frame for 1 cycle: all outputs at reset values next cycle; no beats until a new Control_start.
// 6. Row=0, Col=128: done pulses 1 cycle after start, tvalid never asserts, busy low thereafter.

Source files
------------

// File: rtl/sa3d_pkg.sv
// Shared constants, FSM state type and helpers for the SA3D stream blocks.
package sa3d_pkg;

  localparam int SA3D_DATA_W = 64;
  localparam int SA3D_LANES  = SA3D_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  // Number of beats needed to carry n int8 elements over 'lanes' byte lanes.
  function automatic logic [31:0] ceil_div_lanes(input logic [31:0] n, input int unsigned lanes);
    return (n + 32'(lanes) - 32'd1) / 32'(lanes);
  endfunction

endpackage

// File: rtl/sa3d_sync_fifo_fwft.sv
// First-word-fall-through synchronous FIFO; head entry is visible on rd_data_o
// whenever valid_o is high. clr_i empties the FIFO in one cycle.
module sa3d_sync_fifo_fwft #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clr_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  output logic              full_o,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              valid_o
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       cnt_q;
  logic              push, pop;

  assign valid_o   = (cnt_q != '0);
  assign full_o    = (cnt_q == (AW+1)'(DEPTH));
  assign pop       = rd_en_i && valid_o;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = wr_en_i && (!full_o || pop);
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/sa3d_mm2s_tx.sv
// SA3D output AXI4-Stream transmitter: buffers result beats and frames them with
// tkeep/tlast. Optional stall counter enabled by SA3D_MM2S_STALL_CNT_EN.
module sa3d_mm2s_tx
  import sa3d_pkg::*;
#(
  parameter int DATA_W     = SA3D_DATA_W,
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Control_start,
  input  logic [DIM_W-1:0]    Img2Col_OutMatrix_Row,
  input  logic [DIM_W-1:0]    Img2Col_OutMatrix_Col,
  input  logic                res_valid,
  output logic                res_ready,
  input  logic [DATA_W-1:0]   res_data,
  output logic [DATA_W-1:0]   m_axis_mm2s_tdata,
  output logic [DATA_W/8-1:0] m_axis_mm2s_tkeep,
  output logic                m_axis_mm2s_tlast,
  output logic                m_axis_mm2s_tvalid,
  input  logic                m_axis_mm2s_tready,
  output logic                busy,
  output logic                done
`ifdef SA3D_MM2S_STALL_CNT_EN
  ,output logic [31:0]        stall_cnt
`endif
);

  localparam int LANES = DATA_W / 8;
  localparam int LW    = $clog2(LANES);

  state_e           state_q;
  logic [DIM_W-1:0] row_cfg_q, col_cfg_q, bpr_q;
  logic [DIM_W-1:0] col_beat_q, row_cnt_q;
  logic [31:0]      total_q, in_cnt_q;
  logic             done_q;

  logic [DIM_W-1:0] bpr_w;
  logic [31:0]      total_w;
  logic             fifo_full, fifo_valid, push, pop;
  logic [DATA_W-1:0] fifo_data;
  logic             last_col, last_row;
  logic [LW-1:0]    rem;
  logic [LANES-1:0] tail_keep, keep_w;

  assign bpr_w   = DIM_W'(ceil_div_lanes(32'(Img2Col_OutMatrix_Col), LANES));
  assign total_w = 32'(Img2Col_OutMatrix_Row) * 32'(bpr_w);

  assign res_ready = (state_q == RUN) && !fifo_full && (in_cnt_q < total_q);
  assign push      = res_valid && res_ready;
  assign pop       = m_axis_mm2s_tvalid && m_axis_mm2s_tready;

  sa3d_sync_fifo_fwft #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (Control_start),
    .wr_en_i   (push),
    .wr_data_i (res_data),
    .full_o    (fifo_full),
    .rd_en_i   (pop),
    .rd_data_o (fifo_data),
    .valid_o   (fifo_valid)
  );

  // Framing derives only from counters that move on handshakes, so the beat
  // attributes stay stable while the sink stalls.
  assign last_col  = (col_beat_q == bpr_q - DIM_W'(1));
  assign last_row  = (row_cnt_q == row_cfg_q - DIM_W'(1));
  assign rem       = col_cfg_q[LW-1:0];
  assign tail_keep = LANES'((32'd1 << rem) - 32'd1);
  assign keep_w    = (last_col && rem != '0) ? tail_keep : '1;

  assign m_axis_mm2s_tvalid = fifo_valid;
  assign m_axis_mm2s_tdata  = fifo_valid ? fifo_data : '0;
  assign m_axis_mm2s_tkeep  = fifo_valid ? keep_w : '0;
  assign m_axis_mm2s_tlast  = fifo_valid && last_col && last_row;

  assign busy = (state_q != IDLE);
  assign done = done_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      row_cfg_q  <= '0;
      col_cfg_q  <= '0;
      bpr_q      <= '0;
      total_q    <= '0;
      in_cnt_q   <= '0;
      col_beat_q <= '0;
      row_cnt_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (Control_start) begin
        // Fresh start or abort of a running frame: no done for the old frame.
        row_cfg_q  <= Img2Col_OutMatrix_Row;
        col_cfg_q  <= Img2Col_OutMatrix_Col;
        bpr_q      <= bpr_w;
        total_q    <= total_w;
        in_cnt_q   <= '0;
        col_beat_q <= '0;
        row_cnt_q  <= '0;
        if (total_w == '0) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end else begin
          state_q <= RUN;
        end
      end else begin
        if (push) in_cnt_q <= in_cnt_q + 32'd1;
        if (pop) begin
          if (last_col) begin
            col_beat_q <= '0;
            row_cnt_q  <= row_cnt_q + DIM_W'(1);
          end else begin
            col_beat_q <= col_beat_q + DIM_W'(1);
          end
        end
        case (state_q)
          RUN:     if (push && (in_cnt_q + 32'd1 == total_q)) state_q <= DRAIN;
          DRAIN:   if (pop && m_axis_mm2s_tlast) begin
                     state_q <= IDLE;
                     done_q  <= 1'b1;
                   end
          default: state_q <= state_q;
        endcase
      end
    end
  end

`ifdef SA3D_MM2S_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || Control_start) begin
      stall_cnt_q <= '0;
    end else if (m_axis_mm2s_tvalid && !m_axis_mm2s_tready && stall_cnt_q != '1) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_sa3d_mm2s_tx.sv
// Directed bench for sa3d_mm2s_tx: framing, back-pressure, abort, reset, empty frames.
module tb_sa3d_mm2s_tx;

  logic        clk = 1'b0;
  logic        reset, Control_start;
  logic [15:0] row_i, col_i;
  logic        res_valid, res_ready;
  logic [63:0] res_data, tdata;
  logic [7:0]  tkeep;
  logic        tlast, tvalid, tready, busy, done;
`ifdef SA3D_MM2S_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;
  int max_occ, stalls;

  always #5 clk = ~clk;

  sa3d_mm2s_tx #(.DATA_W(64), .FIFO_DEPTH(16), .DIM_W(16)) dut (
    .clk                   (clk),
    .reset                 (reset),
    .Control_start         (Control_start),
    .Img2Col_OutMatrix_Row (row_i),
    .Img2Col_OutMatrix_Col (col_i),
    .res_valid             (res_valid),
    .res_ready             (res_ready),
    .res_data              (res_data),
    .m_axis_mm2s_tdata     (tdata),
    .m_axis_mm2s_tkeep     (tkeep),
    .m_axis_mm2s_tlast     (tlast),
    .m_axis_mm2s_tvalid    (tvalid),
    .m_axis_mm2s_tready    (tready),
    .busy                  (busy),
    .done                  (done)
`ifdef SA3D_MM2S_STALL_CNT_EN
    ,.stall_cnt            (stall_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pat(input int f, input int i);
    return {8'(f), 24'hC0FFEE, 32'(i)};
  endfunction

  function automatic logic [7:0] exp_keep(input int col, input int i);
    int bpr;
    bpr = (col + 7) / 8;
    if ((i % bpr) == bpr - 1 && (col % 8) != 0) return 8'((1 << (col % 8)) - 1);
    return 8'hFF;
  endfunction

  // Start a frame and stream it; stop_after>=0 leaves the frame after that many output beats.
  task automatic run_frame(input int f, input int row, input int col, input int period,
                           input int stop_after, input int max_cyc);
    int total, sent, got;
    bit fin, prev_stall;
    logic [63:0] prev_data;
    total = row * ((col + 7) / 8);
    sent = 0; got = 0; fin = (total == 0); prev_stall = 0; prev_data = '0;
    max_occ = 0; stalls = 0;
    @(negedge clk);
    Control_start = 1'b1; row_i = 16'(row); col_i = 16'(col);
    res_valid = 1'b0; tready = 1'b0;
    @(negedge clk);
    Control_start = 1'b0;
    for (int c = 0; c < max_cyc; c++) begin
      if (stop_after >= 0 && got >= stop_after) break;
      res_valid = (sent < total);
      res_data  = pat(f, sent);
      tready    = ((c % period) == period - 1);
      #1;
      chk("done", done, fin);
      chk("busy", busy, !fin);
      chk("tvalid", tvalid, sent != got);
      chk("res_ready", res_ready, (sent < total) && ((sent - got) < 16));
      if (prev_stall) chk("hold_data", tdata, prev_data);
      if (fin) break;
      if (tvalid && tready) begin
        chk("tdata", tdata, pat(f, got));
        chk("tkeep", tkeep, exp_keep(col, got));
        chk("tlast", tlast, got == total - 1);
        if (got == total - 1) fin = 1;
        got++;
      end
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      if (prev_stall) stalls++;
      if (res_valid && res_ready) sent++;
      if (sent - got > max_occ) max_occ = sent - got;
      @(negedge clk);
    end
    res_valid = 1'b0; tready = 1'b0;
    if (stop_after >= 0) chk("abort_point", got, stop_after);
    else                 chk("frame_complete", fin, 1);
  endtask

  task automatic idle_check(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk("idle_tvalid", tvalid, 0);
      chk("idle_res_ready", res_ready, 0);
      chk("idle_busy", busy, 0);
      chk("idle_done", done, 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; Control_start = 1'b0; row_i = '0; col_i = '0;
    res_valid = 1'b0; res_data = '0; tready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tlast", tlast, 0);
    chk("rst_tkeep", tkeep, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_res_ready", res_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SA3D_MM2S_STALL_CNT_EN
    chk("rst_stall_cnt", stall_cnt, 0);
`endif
    reset = 1'b0;

    // 1: 4 full beats
    run_frame(1, 2, 16, 1, -1, 100);
    // 2: 20-column rows leave a 4-byte tail (tkeep 0x0F on beats 3, 6, 9)
    run_frame(2, 3, 20, 1, -1, 100);
    // 3: heavy back-pressure fills the FIFO
    run_frame(3, 4, 128, 4, -1, 1000);
    chk("fifo_fill", max_occ, 16);
`ifdef SA3D_MM2S_STALL_CNT_EN
    chk("stall_cnt", stall_cnt, stalls);
`endif
    // 4: abort after 5 beats, then a new frame from count 0
    run_frame(4, 8, 64, 1, 5, 200);
    run_frame(5, 2, 24, 1, -1, 100);
    // 5: reset mid-frame
    run_frame(6, 4, 128, 1, 3, 100);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("mid_rst_tvalid", tvalid, 0);
    chk("mid_rst_tlast", tlast, 0);
    chk("mid_rst_tkeep", tkeep, 0);
    chk("mid_rst_tdata", tdata, 0);
    chk("mid_rst_res_ready", res_ready, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    res_valid = 1'b1; res_data = 64'hDEAD_BEEF_0000_0001; tready = 1'b1;
    idle_check(5);
    res_valid = 1'b0; tready = 1'b0;
    // 6: empty frame
    run_frame(7, 0, 128, 1, -1, 20);
    idle_check(4);
    // single-beat frame after all of the above
    run_frame(8, 1, 8, 1, -1, 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
